phase_sequencer: RTL and testbench

Parametrised multi-cycle CPU timing generator. Steps a phase index through up to MAX_PHASES phases per instruction and drives a one-hot phase strobe bus to the datapath control. Adds several controls to the fixed five-phase generator:
- variable instruction length (early end)
- stall hold
- single-step/halt via start and halt requests
- a retired-instruction counter

Sits between the system clock and the multi-cycle control unit.

---
 rtl/cpu_timing_pkg.sv | 20 ++
 rtl/phase_decode.sv | 25 ++
 rtl/phase_sequencer.sv | 111 +++++++++++
 tb/tb_phase_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cpu_timing_pkg.sv
// Shared definitions for the multi-cycle CPU timing logic.
//   seq_state_t    : sequencer state (IDLE, RUN)
//   DEFAULT_PHASES : phase count of the classic five-phase CPU
//   IF..WB         : phase index names for the five-phase CPU
package cpu_timing_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    localparam int unsigned DEFAULT_PHASES = 5;

    localparam int unsigned IF  = 0;
    localparam int unsigned ID  = 1;
    localparam int unsigned EX  = 2;
    localparam int unsigned MEM = 3;
    localparam int unsigned WB  = 4;

endpackage

// File: rtl/phase_decode.sv
// Phase index to one-hot strobe decoder (purely combinational).
//   idx : current phase index
//   run : high while an instruction is executing
//   p   : one-hot strobe, bit idx set when run=1, all zero otherwise
module phase_decode #(
    parameter int unsigned MAX_PHASES = 5,
    parameter int unsigned PW         = $clog2(MAX_PHASES)
) (
    input  logic [PW-1:0]         idx,
    input  logic                  run,
    output logic [MAX_PHASES-1:0] p
);

    always_comb begin
        p = '0;
        if (run) begin
            for (int unsigned k = 0; k < MAX_PHASES; k++) begin
                if (idx == PW'(k)) begin
                    p[k] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle CPU timing generator. Steps a phase index through up to
// MAX_PHASES phases per instruction with early end, stall hold,
// start/halt (single-step) control and a retired-instruction counter.
//   clk       : system clock
//   nclr      : synchronous active-low reset
//   go        : start an instruction from IDLE
//   stall     : hold the current phase (RUN only)
//   early_end : current phase is the instruction's last (ignored in phase 0)
//   halt      : return to IDLE at the next instruction boundary
//   p         : one-hot phase strobe, zero in IDLE
//   phase     : current phase index, 0 in IDLE
//   idle      : high in IDLE
//   halt_pend : halt latched but not yet honoured
//   instr_cnt : completed-instruction count (wraps)
module phase_sequencer
    import cpu_timing_pkg::*;
#(
    parameter int unsigned MAX_PHASES = DEFAULT_PHASES,
    parameter int unsigned PW         = $clog2(MAX_PHASES),
    parameter int unsigned CW         = 16
) (
    input  logic                  clk,
    input  logic                  nclr,
    input  logic                  go,
    input  logic                  stall,
    input  logic                  early_end,
    input  logic                  halt,
    output logic [MAX_PHASES-1:0] p,
    output logic [PW-1:0]         phase,
    output logic                  idle,
    output logic                  halt_pend,
    output logic [CW-1:0]         instr_cnt
);

    seq_state_t    state_q, state_n;
    logic [PW-1:0] phase_q, phase_n;
    logic          halt_q,  halt_n;
    logic [CW-1:0] cnt_q,   cnt_n;
    logic          last_phase;

    // Early end only counts from phase 1 on: fetch always spans phases 0 and 1.
    assign last_phase = (phase_q == PW'(MAX_PHASES - 1)) ||
                        (early_end && (phase_q != '0));

    always_ff @(posedge clk) begin
        if (!nclr) begin
            state_q <= IDLE;
            phase_q <= '0;
            halt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            phase_q <= phase_n;
            halt_q  <= halt_n;
            cnt_q   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state_q;
        phase_n = phase_q;
        halt_n  = halt_q;
        cnt_n   = cnt_q;
        unique case (state_q)
            IDLE: begin
                phase_n = '0;
                halt_n  = 1'b0;
                if (go) begin
                    state_n = RUN;
                    // go+halt together: run exactly one instruction.
                    halt_n  = halt;
                end
            end
            RUN: begin
                if (stall) begin
                    halt_n = halt_q | halt;
                end else if (last_phase) begin
                    cnt_n   = cnt_q + CW'(1);
                    phase_n = '0;
                    if (halt_q || halt) begin
                        state_n = IDLE;
                        halt_n  = 1'b0;
                    end
                end else begin
                    phase_n = phase_q + PW'(1);
                    halt_n  = halt_q | halt;
                end
            end
            default: begin
                state_n = IDLE;
                phase_n = '0;
                halt_n  = 1'b0;
            end
        endcase
    end

    phase_decode #(
        .MAX_PHASES (MAX_PHASES),
        .PW         (PW)
    ) u_decode (
        .idx (phase_q),
        .run (state_q == RUN),
        .p   (p)
    );

    assign phase     = phase_q;
    assign idle      = (state_q == IDLE);
    assign halt_pend = halt_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

    typedef struct {
        logic        nclr;
        logic        go;
        logic        stall;
        logic        ee;
        logic        halt;
        logic [4:0]  p;
        logic        idle;
        logic        hp;
        logic [15:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main five-phase instance, table driven.
    logic        nclr = 1'b0, go = 1'b0, stall = 1'b0, early_end = 1'b0, halt = 1'b0;
    logic [4:0]  p5;
    logic [2:0]  ph5;
    logic        idle5, hp5;
    logic [15:0] cnt5;

    phase_sequencer #(.MAX_PHASES(5)) dut5 (
        .clk(clk), .nclr(nclr), .go(go), .stall(stall), .early_end(early_end),
        .halt(halt), .p(p5), .phase(ph5), .idle(idle5), .halt_pend(hp5),
        .instr_cnt(cnt5)
    );

    // Free-running instances for counter wrap and parameter sweep.
    logic        nclr_s = 1'b0;
    logic        one = 1'b1, zero = 1'b0;
    logic [4:0]  pw;   logic [2:0] phw;  logic idlew, hpw;  logic [3:0]  cntw;
    logic [1:0]  p2;   logic [0:0] ph2;  logic idle2, hp2;  logic [15:0] cnt2;
    logic [15:0] p16;  logic [3:0] ph16; logic idle16, hp16; logic [15:0] cnt16;

    phase_sequencer #(.MAX_PHASES(5), .CW(4)) dutw (
        .clk(clk), .nclr(nclr_s), .go(one), .stall(zero), .early_end(zero),
        .halt(zero), .p(pw), .phase(phw), .idle(idlew), .halt_pend(hpw),
        .instr_cnt(cntw)
    );
    phase_sequencer #(.MAX_PHASES(2)) dut2 (
        .clk(clk), .nclr(nclr_s), .go(one), .stall(zero), .early_end(zero),
        .halt(zero), .p(p2), .phase(ph2), .idle(idle2), .halt_pend(hp2),
        .instr_cnt(cnt2)
    );
    phase_sequencer #(.MAX_PHASES(16)) dut16 (
        .clk(clk), .nclr(nclr_s), .go(one), .stall(zero), .early_end(zero),
        .halt(zero), .p(p16), .phase(ph16), .idle(idle16), .halt_pend(hp16),
        .instr_cnt(cnt16)
    );

    int unsigned nvec  = 0;
    int unsigned nfail = 0;
    vec_t tbl[$];
    vec_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic v(input logic n, input logic g, input logic s, input logic e,
                     input logic h, input logic [4:0] ep, input logic ei,
                     input logic eh, input logic [15:0] ec);
        vec_t r;
        r.nclr = n; r.go = g; r.stall = s; r.ee = e; r.halt = h;
        r.p = ep; r.idle = ei; r.hp = eh; r.cnt = ec;
        tbl.push_back(r);
    endtask

    function automatic logic [31:0] idx_of(input logic [4:0] oh);
        logic [31:0] r = 0;
        for (int k = 0; k < 5; k++) if (oh[k]) r = k;
        return r;
    endfunction

    initial begin
        //  nclr go st ee ht  p         idle hp cnt
        v(0, 0, 0, 0, 0, 5'b00000, 1, 0, 0);
        v(0, 1, 1, 1, 1, 5'b00000, 1, 0, 0);   // reset overrides everything
        v(1, 1, 0, 0, 0, 5'b00001, 0, 0, 0);
        v(1, 1, 0, 0, 0, 5'b00010, 0, 0, 0);
        v(1, 1, 0, 0, 0, 5'b00100, 0, 0, 0);
        v(1, 1, 0, 0, 0, 5'b01000, 0, 0, 0);
        v(1, 1, 0, 0, 0, 5'b10000, 0, 0, 0);
        v(1, 1, 0, 0, 0, 5'b00001, 0, 0, 1);
        v(1, 1, 0, 1, 0, 5'b00010, 0, 0, 1);   // early_end in phase 0 ignored
        v(1, 1, 0, 0, 0, 5'b00100, 0, 0, 1);
        v(1, 1, 0, 1, 0, 5'b00001, 0, 0, 2);   // early end in phase 2
        v(1, 1, 0, 0, 0, 5'b00010, 0, 0, 2);
        v(1, 1, 0, 0, 0, 5'b00100, 0, 0, 2);
        v(1, 1, 0, 0, 0, 5'b01000, 0, 0, 2);
        v(1, 1, 1, 0, 0, 5'b01000, 0, 0, 2);   // stall x3, early_end mid
        v(1, 1, 1, 1, 0, 5'b01000, 0, 0, 2);
        v(1, 1, 1, 0, 0, 5'b01000, 0, 0, 2);
        v(1, 1, 0, 0, 0, 5'b10000, 0, 0, 2);
        v(1, 1, 0, 0, 0, 5'b00001, 0, 0, 3);
        v(1, 1, 0, 0, 1, 5'b00010, 0, 1, 3);   // halt latched mid-instruction
        v(1, 1, 0, 0, 0, 5'b00100, 0, 1, 3);
        v(1, 1, 0, 0, 0, 5'b01000, 0, 1, 3);
        v(1, 1, 0, 0, 0, 5'b10000, 0, 1, 3);
        v(1, 1, 0, 0, 0, 5'b00000, 1, 0, 4);
        v(1, 0, 1, 1, 1, 5'b00000, 1, 0, 4);   // halt/stall/ee inert in IDLE
        v(1, 1, 0, 0, 1, 5'b00001, 0, 1, 4);   // single-step
        v(1, 1, 0, 0, 0, 5'b00010, 0, 1, 4);
        v(1, 1, 0, 0, 0, 5'b00100, 0, 1, 4);
        v(1, 1, 0, 0, 0, 5'b01000, 0, 1, 4);
        v(1, 1, 0, 0, 0, 5'b10000, 0, 1, 4);
        v(1, 1, 0, 0, 0, 5'b00000, 1, 0, 5);
        v(1, 1, 0, 0, 0, 5'b00001, 0, 0, 5);
        v(1, 1, 0, 0, 0, 5'b00010, 0, 0, 5);
        v(1, 1, 0, 1, 1, 5'b00000, 1, 0, 6);   // halt on early final phase
        v(1, 1, 0, 0, 0, 5'b00001, 0, 0, 6);
        v(1, 1, 0, 0, 0, 5'b00010, 0, 0, 6);
        v(1, 1, 0, 0, 0, 5'b00100, 0, 0, 6);
        v(1, 1, 0, 0, 0, 5'b01000, 0, 0, 6);
        v(1, 0, 0, 0, 0, 5'b10000, 0, 0, 6);
        v(1, 0, 0, 0, 1, 5'b00000, 1, 0, 7);   // halt on full-length final phase
        v(1, 1, 0, 0, 0, 5'b00001, 0, 0, 7);
        v(1, 1, 0, 0, 0, 5'b00010, 0, 0, 7);
        v(1, 1, 0, 0, 0, 5'b00100, 0, 0, 7);
        v(0, 1, 1, 0, 0, 5'b00000, 1, 0, 0);   // reset mid-instruction under stall
        v(1, 0, 0, 0, 0, 5'b00000, 1, 0, 0);
        v(1, 1, 1, 0, 0, 5'b00001, 0, 0, 0);   // stall ignored in IDLE
        v(1, 0, 1, 0, 1, 5'b00001, 0, 1, 0);   // halt latched during stall
        v(1, 0, 0, 0, 0, 5'b00010, 0, 1, 0);
        v(1, 0, 0, 1, 0, 5'b00000, 1, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t e;
            @(negedge clk);
            nclr = tbl[i].nclr; go = tbl[i].go; stall = tbl[i].stall;
            early_end = tbl[i].ee; halt = tbl[i].halt;
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("v%0d.p", i),     32'(p5),    32'(e.p));
            check($sformatf("v%0d.phase", i), 32'(ph5),   idx_of(e.p));
            check($sformatf("v%0d.idle", i),  32'(idle5), 32'(e.idle));
            check($sformatf("v%0d.hp", i),    32'(hp5),   32'(e.hp));
            check($sformatf("v%0d.cnt", i),   32'(cnt5),  32'(e.cnt));
        end

        // Free-run sweep: MAX_PHASES 2/5/16, and 4-bit counter wrap.
        @(negedge clk);
        nclr_s = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("sw.idle2",  32'(idle2),  32'd1);
        check("sw.idle16", 32'(idle16), 32'd1);
        check("sw.cntw0",  32'(cntw),   32'd0);
        @(negedge clk);
        nclr_s = 1'b1;
        for (int n = 1; n <= 90; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("s%0d.p2", n),    32'(p2),    32'(1) << ((n - 1) % 2));
            check($sformatf("s%0d.ph2", n),   32'(ph2),   32'((n - 1) % 2));
            check($sformatf("s%0d.cnt2", n),  32'(cnt2),  32'((n - 1) / 2));
            check($sformatf("s%0d.p16", n),   32'(p16),   32'(1) << ((n - 1) % 16));
            check($sformatf("s%0d.ph16", n),  32'(ph16),  32'((n - 1) % 16));
            check($sformatf("s%0d.cnt16", n), 32'(cnt16), 32'((n - 1) / 16));
            check($sformatf("s%0d.pw", n),    32'(pw),    32'(1) << ((n - 1) % 5));
            check($sformatf("s%0d.cntw", n),  32'(cntw),  32'(((n - 1) / 5) % 16));
            check($sformatf("s%0d.idle", n),  32'({idlew, idle2, idle16}), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
